corr_sliding_detector: RTL and testbench
========================================

// Module: corr_sliding_detector
// PURPOSE
//  Streaming sliding-window bit-pattern correlator, parametrised in length/pattern, with error tolerance.
//  Scores every accepted beat, not only the frame end, and emits one result beat per input beat.
//  Sits between bit-stream demod output and frame-sync logic; AXI-Stream-style in and out.
// PARAMETERS
//  SEQ_LEN     11               pattern length in bits (2..64)
//  SEQ_PATTERN 11'b11100010010  reference pattern; MSB = oldest bit received
//  MAX_ERR     0                max mismatching bits still reported as match (0..SEQ_LEN/2)
//  SCORE_W     $clog2(SEQ_LEN+1) width of agreement score (derived, do not override)
// PORTS
//  i_clk     in   1        clock
//  i_rst_n   in   1        synchronous reset, active-low
//  s_tdata   in   1        input bit
//  s_tvalid  in   1        input beat valid
//  s_tlast   in   1        last bit of input frame
//  s_tready  out  1        input accept
//  m_tvalid  out  1        result beat valid
//  m_tready  in   1        downstream accept
//  m_tdata   out  SCORE_W  agreement score = SEQ_LEN - mismatches (window contents vs pattern)
//  m_tuser   out  2        [0] pattern match, [1] inverted-pattern match (see CONFIGURATION)
//  m_tlast   out  1        echo of s_tlast of the scored beat
// BEHAVIOUR
//  Reset (i_rst_n=0 at posedge): window=0, fill_cnt=0, stage1 valid=0, m_tvalid=0, m_tdata=0,
//   m_tuser=2'b00, m_tlast=0. s_tready forced 0 while i_rst_n=0.
//  advance = !m_tvalid | m_tready; s_tready = i_rst_n & advance (combinational).
//  Beat accepted when s_tvalid & s_tready: window <= {window[SEQ_LEN-2:0], s_tdata};
//   fill_cnt saturates at SEQ_LEN.
//  Pipeline, all stages move only on advance:
//   S1: register window XOR SEQ_PATTERN, full flag (fill_cnt reached SEQ_LEN incl. this beat), tlast.
//   S2: popcount of S1 mismatch vector -> m_tdata, m_tuser, m_tlast, m_tvalid.
//  Latency: accepted beat at cycle N -> m_tvalid with its result at N+2 (no backpressure).
//  Bubble (no accept while advance=1): S1 valid=0 propagates; m_tvalid drops 0 next cycle.
//  m_tvalid=1 & m_tready=0: m_tdata/m_tuser/m_tlast/m_tvalid hold stable; S1 holds; no input accepted.
//  m_tuser[0] = full & (mismatches <= MAX_ERR). Not full: m_tuser=00, m_tdata still reported.
//  Frame boundary: beat with s_tlast=1 is scored normally, then window and fill_cnt clear,
//   so patterns never straddle frames. tlast on first beat of a frame: scored with full=0.
//  Pattern repeat/overlap: every beat is scored independently; back-to-back matches each reported.
//  Reset mid-frame: pipeline contents discarded, no result emitted for in-flight beats.
//  Throughput: 1 beat/cycle with m_tready held high.
// CONFIGURATION
//  CORR_INV_DETECT_EN defined: m_tuser[1] = full & (mismatches >= SEQ_LEN-MAX_ERR) (polarity-flipped
//   pattern; score still reports agreement with non-inverted pattern).
//  Not defined: m_tuser[1] tied 0; no extra comparator. Port list identical both ways.
// STRUCTURE
//  Package corr_pkg: CORR_MAX_LEN=64, BARKER11=11'b11100010010, BARKER13 constant,
//   function clog2-based score width helper, typedef corr_result_t {score, match, inv_match, last}.
//  Sub-module corr_popcount #(.W(SEQ_LEN)): combinational adder-tree popcount, used in S2.
//  Top holds window shift reg, fill counter, 2-stage pipeline and handshake.
// TESTING (SEQ_LEN=11, SEQ_PATTERN=BARKER11 unless stated)
//  1 Reset, then 11 bits 1,1,1,0,0,0,1,0,0,1,0 continuous, m_tready=1 -> beat 11 result:
//    m_tdata=11, m_tuser[0]=1, 2 cycles after its accept; beats 1..10 m_tuser=00.
//  2 Same stream with bit 5 flipped: MAX_ERR=0 -> m_tdata=10, m_tuser[0]=0; MAX_ERR=1 -> m_tuser[0]=1.
//  3 Pattern split by s_tlast after bit 6 -> no match on any beat; next frame of full pattern -> match.
//  4 m_tready low 5 cycles mid-stream with s_tvalid=1 -> s_tready=0, outputs held stable,
//    no beat lost or duplicated; result sequence identical to test 1.
//  5 Assert i_rst_n=0 one cycle after bit 10 -> m_tvalid=0 next cycle; bit 11 alone after reset
//    -> m_tuser=00, m_tdata = agreement of zero-padded window.
//  6 CORR_INV_DETECT_EN: send bitwise inverse of pattern -> m_tdata=0, m_tuser=2'b10;
//    macro undefined -> m_tuser=2'b00.

Source files
------------

// File: rtl/corr_pkg.sv
// Shared constants, types and helpers for the sliding-window bit-pattern correlator.
package corr_pkg;

   localparam int CORR_MAX_LEN = 64;
   localparam int CORR_SCORE_MAX_W = $clog2(CORR_MAX_LEN + 1);

   localparam logic [10:0] BARKER11 = 11'b11100010010;
   localparam logic [12:0] BARKER13 = 13'b1111100110101;

   function automatic int corr_score_w(input int seq_len);
      return $clog2(seq_len + 1);
   endfunction

   typedef struct packed {
      logic [CORR_SCORE_MAX_W-1:0] score;
      logic                        match;
      logic                        inv_match;
      logic                        last;
   } corr_result_t;

endpackage

// File: rtl/corr_sliding_detector_if.sv
// Bit-stream input and score output of the correlator, grouped as one bus.
// master = upstream/downstream side, slave = correlator side.
interface corr_sliding_detector_if #(
   parameter int SCORE_W = corr_pkg::corr_score_w(11)
);
   logic               s_tdata;
   logic               s_tvalid;
   logic               s_tlast;
   logic               s_tready;
   logic               m_tvalid;
   logic               m_tready;
   logic [SCORE_W-1:0] m_tdata;
   logic [1:0]         m_tuser;
   logic               m_tlast;

   modport master (
      output s_tdata, s_tvalid, s_tlast, m_tready,
      input  s_tready, m_tvalid, m_tdata, m_tuser, m_tlast
   );

   modport slave (
      input  s_tdata, s_tvalid, s_tlast, m_tready,
      output s_tready, m_tvalid, m_tdata, m_tuser, m_tlast
   );
endinterface

// File: rtl/corr_popcount.sv
// Combinational population count of a W-bit vector.
module corr_popcount #(
   parameter int W  = 11,
   parameter int CW = $clog2(W + 1)
) (
   input  logic [W-1:0]  bits,
   output logic [CW-1:0] count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < W; i++) begin
         count = count + CW'(bits[i]);
      end
   end

endmodule

// File: rtl/corr_sliding_detector.sv
// Sliding-window correlator: scores every accepted bit against SEQ_PATTERN, one result per beat.
// Build option CORR_INV_DETECT_EN adds the inverted-pattern flag on m_tuser[1].
module corr_sliding_detector import corr_pkg::*; #(
   parameter int                 SEQ_LEN     = 11,
   parameter logic [SEQ_LEN-1:0] SEQ_PATTERN = BARKER11,
   parameter int                 MAX_ERR     = 0,
   parameter int                 SCORE_W     = corr_score_w(SEQ_LEN)
) (
   input logic                  i_clk,
   input logic                  i_rst_n,
   corr_sliding_detector_if.slave bus
);

   logic [SEQ_LEN-1:0] window;
   logic [SCORE_W-1:0] fill_cnt;
   logic [SEQ_LEN-1:0] window_next;
   logic [SCORE_W-1:0] fill_next;
   logic               advance;
   logic               accept;

   logic               s1_valid;
   logic [SEQ_LEN-1:0] s1_mism;
   logic               s1_full;
   logic               s1_last;

   logic [SCORE_W-1:0] mism_cnt;
   logic               match;
   logic               inv_match;

   logic               out_valid;
   logic [SCORE_W-1:0] out_data;
   logic [1:0]         out_user;
   logic               out_last;

   assign advance      = !out_valid || bus.m_tready;
   assign bus.s_tready = i_rst_n && advance;
   assign accept       = bus.s_tvalid && bus.s_tready;

   assign window_next = {window[SEQ_LEN-2:0], bus.s_tdata};
   assign fill_next   = (fill_cnt == SCORE_W'(SEQ_LEN)) ? fill_cnt : fill_cnt + SCORE_W'(1);

   corr_popcount #(
      .W  (SEQ_LEN),
      .CW (SCORE_W)
   ) u_popcount (
      .bits  (s1_mism),
      .count (mism_cnt)
   );

   assign match = s1_full && (mism_cnt <= SCORE_W'(MAX_ERR));
`ifdef CORR_INV_DETECT_EN
   assign inv_match = s1_full && (mism_cnt >= SCORE_W'(SEQ_LEN - MAX_ERR));
`else
   assign inv_match = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         window    <= '0;
         fill_cnt  <= '0;
         s1_valid  <= 1'b0;
         s1_mism   <= '0;
         s1_full   <= 1'b0;
         s1_last   <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_user  <= 2'b00;
         out_last  <= 1'b0;
      end else if (advance) begin
         // A frame's last bit is scored with the old window, then the window restarts empty
         if (accept) begin
            window   <= bus.s_tlast ? '0 : window_next;
            fill_cnt <= bus.s_tlast ? '0 : fill_next;
            s1_mism  <= window_next ^ SEQ_PATTERN;
            s1_full  <= (fill_next == SCORE_W'(SEQ_LEN));
            s1_last  <= bus.s_tlast;
         end
         s1_valid  <= accept;
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_data <= SCORE_W'(SEQ_LEN) - mism_cnt;
            out_user <= {inv_match, match};
            out_last <= s1_last;
         end
      end
   end

   assign bus.m_tvalid = out_valid;
   assign bus.m_tdata  = out_data;
   assign bus.m_tuser  = out_user;
   assign bus.m_tlast  = out_last;

endmodule

// File: tb/tb_corr_sliding_detector.sv
// Directed bench for corr_sliding_detector: two instances (MAX_ERR 0 and 1) share one stimulus stream.
module tb_corr_sliding_detector;

   typedef struct {
      int         score;
      logic [1:0] user;
      logic       last;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   corr_sliding_detector_if #(.SCORE_W(4)) bus0();
   corr_sliding_detector_if #(.SCORE_W(4)) bus1();

   assign bus1.s_tdata  = bus0.s_tdata;
   assign bus1.s_tvalid = bus0.s_tvalid;
   assign bus1.s_tlast  = bus0.s_tlast;
   assign bus1.m_tready = bus0.m_tready;

   corr_sliding_detector #(.SEQ_LEN(11), .SEQ_PATTERN(11'b11100010010), .MAX_ERR(0)) u_dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus0.slave));
   corr_sliding_detector #(.SEQ_LEN(11), .SEQ_PATTERN(11'b11100010010), .MAX_ERR(1)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus1.slave));

   int   total = 0;
   int   bad   = 0;
   exp_t q0[$];
   exp_t q1[$];

   logic [10:0] mwin;
   int          mfill;
   int          stall_cnt;
   logic [10:0] pat;
   logic [10:0] flip5;
   logic [10:0] inv_pat;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic inv_flag(input logic full, input int mism, input int max_err);
`ifdef CORR_INV_DETECT_EN
      return full && (mism >= 11 - max_err);
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_accept(input logic b, input logic l);
      exp_t e0, e1;
      logic full;
      int   mism;
      mwin = {mwin[9:0], b};
      if (mfill < 11) mfill++;
      full = (mfill == 11);
      mism = $countones(mwin ^ pat);
      e0.score = 11 - mism; e0.last = l; e0.user = {inv_flag(full, mism, 0), full && (mism <= 0)};
      e1.score = 11 - mism; e1.last = l; e1.user = {inv_flag(full, mism, 1), full && (mism <= 1)};
      q0.push_back(e0);
      q1.push_back(e1);
      if (l) begin
         mwin  = '0;
         mfill = 0;
      end
   endtask

   // Called #1 after a posedge; returns #1 after the posedge that accepted the beat.
   task automatic send_beat(input logic b, input logic l);
      logic ok;
      int   waits;
      bus0.s_tdata  = b;
      bus0.s_tlast  = l;
      bus0.s_tvalid = 1'b1;
      waits = 0;
      ok = 1'b0;
      while (!ok && waits <= 100) begin
         @(negedge clk);
         ok = bus0.s_tready;
         @(posedge clk); #1;
         if (!ok) waits++;
      end
      stall_cnt += waits;
      if (ok) model_accept(b, l);
      else chk("send_timeout", 32'(waits), 32'd0);
   endtask

   task automatic send_bits(input logic [10:0] bits, input int hi, input int lo, input logic last_at_lo);
      for (int i = hi; i >= lo; i--) send_beat(bits[i], last_at_lo && (i == lo));
   endtask

   task automatic idle();
      bus0.s_tvalid = 1'b0;
      bus0.s_tlast  = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk(name, 32'(q0.size() + q1.size()), 32'd0);
   endtask

   task automatic chk_out(input string name, input logic [3:0] d0, input logic [1:0] u0,
                          input logic [3:0] d1, input logic [1:0] u1, input logic l);
      chk({name, "_dut0"}, {bus0.m_tvalid, bus0.m_tlast, bus0.m_tuser, bus0.m_tdata}, {1'b1, l, u0, d0});
      chk({name, "_dut1"}, {bus1.m_tvalid, bus1.m_tlast, bus1.m_tuser, bus1.m_tdata}, {1'b1, l, u1, d1});
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus0.m_tvalid && bus0.m_tready) begin
         if (q0.size() == 0) begin
            chk("unexpected_out_dut0", 32'(bus0.m_tdata), 32'hffff);
         end else begin
            e = q0.pop_front();
            chk("stream_dut0", {bus0.m_tlast, bus0.m_tuser, bus0.m_tdata}, {e.last, e.user, 4'(e.score)});
         end
      end
      if (rst_n && bus1.m_tvalid && bus1.m_tready) begin
         if (q1.size() == 0) begin
            chk("unexpected_out_dut1", 32'(bus1.m_tdata), 32'hffff);
         end else begin
            e = q1.pop_front();
            chk("stream_dut1", {bus1.m_tlast, bus1.m_tuser, bus1.m_tdata}, {e.last, e.user, 4'(e.score)});
         end
      end
   end

   initial begin
      exp_t h;
      logic [1:0] inv_user;
      pat     = 11'b11100010010;
      flip5   = 11'b11101010010;
      inv_pat = 11'b00011101101;
`ifdef CORR_INV_DETECT_EN
      inv_user = 2'b10;
`else
      inv_user = 2'b00;
`endif
      mwin = '0; mfill = 0; stall_cnt = 0;
      rst_n = 1'b0;
      bus0.s_tdata = 1'b0; bus0.s_tvalid = 1'b1; bus0.s_tlast = 1'b0; bus0.m_tready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tready", {bus0.s_tready, bus1.s_tready}, 2'b00);
      chk("rst_out_dut0", {bus0.m_tvalid, bus0.m_tlast, bus0.m_tuser, bus0.m_tdata}, 8'h00);
      chk("rst_out_dut1", {bus1.m_tvalid, bus1.m_tlast, bus1.m_tuser, bus1.m_tdata}, 8'h00);
      bus0.s_tvalid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("tready_after_rst", bus0.s_tready, 1'b1);

      // exact pattern, full rate, result two cycles after last accept, then a bubble
      stall_cnt = 0;
      send_bits(pat, 10, 0, 1'b1);
      idle();
      chk("full_rate", 32'(stall_cnt), 32'd0);
      @(posedge clk); #1;
      chk_out("exact_match", 4'd11, 2'b01, 4'd11, 2'b01, 1'b1);
      @(posedge clk); #1;
      chk("bubble_valid", {bus0.m_tvalid, bus1.m_tvalid}, 2'b00);
      wait_drain("drain_exact");

      // one bit flipped: only the tolerant instance matches
      send_bits(flip5, 10, 0, 1'b1);
      idle();
      @(posedge clk); #1;
      chk_out("one_err", 4'd10, 2'b00, 4'd10, 2'b01, 1'b1);
      wait_drain("drain_one_err");

      // pattern split across a frame boundary never matches, a whole frame afterwards does
      send_bits(pat, 10, 5, 1'b1);
      send_bits(pat, 4, 0, 1'b1);
      send_bits(pat, 10, 0, 1'b1);
      idle();
      @(posedge clk); #1;
      chk_out("after_split", 4'd11, 2'b01, 4'd11, 2'b01, 1'b1);
      wait_drain("drain_split");

      // single-beat frame: window 00000000001 vs pattern -> 6 mismatches
      send_beat(1'b1, 1'b1);
      idle();
      @(posedge clk); #1;
      chk_out("one_beat_frame", 4'd5, 2'b00, 4'd5, 2'b00, 1'b1);
      wait_drain("drain_one_beat");

      // downstream stall for 5 cycles with input pending
      send_bits(pat, 10, 6, 1'b0);
      bus0.m_tready = 1'b0;
      bus0.s_tdata  = pat[5];
      bus0.s_tlast  = 1'b0;
      bus0.s_tvalid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         if (q0.size() == 0) begin
            chk("stall_queue", 32'd0, 32'd1);
         end else begin
            h = q0[0];
            chk("stall_hold", {bus0.s_tready, bus0.m_tvalid, bus0.m_tlast, bus0.m_tuser, bus0.m_tdata},
                {1'b0, 1'b1, h.last, h.user, 4'(h.score)});
         end
      end
      bus0.m_tready = 1'b1;
      send_bits(pat, 5, 0, 1'b1);
      idle();
      @(posedge clk); #1;
      chk_out("after_stall", 4'd11, 2'b01, 4'd11, 2'b01, 1'b1);
      wait_drain("drain_stall");

      // reset one cycle after bit 10 drops everything in flight
      send_bits(pat, 10, 1, 1'b0);
      idle();
      rst_n = 1'b0;
      q0.delete();
      q1.delete();
      mwin = '0; mfill = 0;
      @(posedge clk); #1;
      chk("rst_mid_valid", {bus0.m_tvalid, bus1.m_tvalid, bus0.s_tready}, 3'b000);
      rst_n = 1'b1;
      send_beat(pat[0], 1'b1);
      idle();
      @(posedge clk); #1;
      chk_out("bit11_alone", 4'd6, 2'b00, 4'd6, 2'b00, 1'b1);
      wait_drain("drain_reset");

      // inverted pattern
      send_bits(inv_pat, 10, 0, 1'b1);
      idle();
      @(posedge clk); #1;
      chk_out("inverted", 4'd0, inv_user, 4'd0, inv_user, 1'b1);
      wait_drain("drain_inverted");

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
